// File: rtl/apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// apb_req_arbiter
// Two-port request arbiter in front of an APB master internal port. Each
// requester owns a one-entry buffer; buffered requests are issued one at a
// time to the master and the completion (with read data) is routed back to
// the requester that issued it.
//
// Parameters
//   RR_EN        1 = round-robin between the two ports, 0 = port 0 always wins
// Ports
//   PCLK, PRESET             clock (rising edge), async active-high reset
//   pN_transfer              one-cycle request pulse from requester N
//   pN_addr/wdata/write      request fields, sampled with pN_transfer
//   pN_ready                 one-cycle completion pulse to requester N
//   pN_rdata                 read data, held until the port's next completion
//   pN_busy                  request of port N pending or in service
//   pN_err                   one-cycle pulse when a pN_transfer was dropped
//   m_transfer               one-cycle issue pulse to the APB master
//   m_addr/wdata/write       request presented to the APB master
//   m_ready, m_rdata         master completion and read data
// ---------------------------------------------------------------------------
module apb_req_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        p0_transfer,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic        p0_write,
    output logic        p0_ready,
    output logic [31:0] p0_rdata,
    output logic        p0_busy,
    output logic        p0_err,
    input  logic        p1_transfer,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic        p1_write,
    output logic        p1_ready,
    output logic [31:0] p1_rdata,
    output logic        p1_busy,
    output logic        p1_err,
    output logic        m_transfer,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_write,
    input  logic        m_ready,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;

    logic [1:0]  xfer_s;
    logic [31:0] in_addr_s  [2];
    logic [31:0] in_wdata_s [2];
    logic [1:0]  in_write_s;

    logic [1:0]  pend_r;
    logic [31:0] addr_r  [2];
    logic [31:0] wdata_r [2];
    logic [1:0]  write_r;

    // Port granted by the most recent issue; doubles as the round-robin
    // history. Reset to 1 so that port 0 wins the first contest.
    logic        gnt_r;

    logic        issue_s;
    logic        win_s;
    logic        sel_s;
    logic        drive_s;
    logic        complete_s;

    logic [1:0]  ready_r;
    logic [1:0]  err_r;
    logic [31:0] rdata_r [2];

    assign xfer_s        = {p1_transfer, p0_transfer};
    assign in_addr_s[0]  = p0_addr;
    assign in_addr_s[1]  = p1_addr;
    assign in_wdata_s[0] = p0_wdata;
    assign in_wdata_s[1] = p1_wdata;
    assign in_write_s    = {p1_write, p0_write};

    // Next-state logic and winner selection for the issue slot in IDLE
    always_comb begin
        state_next_s = state_r;
        issue_s      = 1'b0;
        win_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (pend_r != 2'b00) begin
                    issue_s      = 1'b1;
                    state_next_s = SETUP;
                    if (pend_r == 2'b11) begin
                        if (RR_EN) begin
                            win_s = ~gnt_r;
                        end else begin
                            win_s = 1'b0;
                        end
                    end else begin
                        win_s = pend_r[1];
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            // The master's slave mux may already show ready here; ignore it.
            SETUP: begin
                state_next_s = ACCESS;
            end
            ACCESS: begin
                if (m_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = ACCESS;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    assign complete_s = (state_r == ACCESS) && m_ready;
    // During the issue cycle the grant is not yet recorded, so use the winner.
    assign sel_s      = issue_s ? win_s : gnt_r;
    assign drive_s    = issue_s || (state_r != IDLE);

    // Master-side request fields: granted buffer while active, zero otherwise
    always_comb begin
        m_transfer = issue_s;
        if (drive_s) begin
            m_addr  = addr_r[sel_s];
            m_wdata = wdata_r[sel_s];
            m_write = write_r[sel_s];
        end else begin
            m_addr  = 32'd0;
            m_wdata = 32'd0;
            m_write = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Last-grant register, refreshed on every issue
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            gnt_r <= 1'b1;
        end else if (issue_s) begin
            gnt_r <= win_s;
        end
    end

    // Per-port request buffers; a pulse is only accepted while not busy
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            pend_r  <= 2'b00;
            write_r <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                addr_r[i]  <= 32'd0;
                wdata_r[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (complete_s && (gnt_r == 1'(i))) begin
                    pend_r[i] <= 1'b0;
                end else if (xfer_s[i] && !pend_r[i]) begin
                    pend_r[i]  <= 1'b1;
                    addr_r[i]  <= in_addr_s[i];
                    wdata_r[i] <= in_wdata_s[i];
                    write_r[i] <= in_write_s[i];
                end
            end
        end
    end

    // Requester-side responses: completion pulse, read data, overrun pulse
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ready_r <= 2'b00;
            err_r   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                rdata_r[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                ready_r[i] <= complete_s && (gnt_r == 1'(i));
                // pend_r is still set in the completion cycle, so a pulse
                // there is dropped as well.
                err_r[i]   <= xfer_s[i] && pend_r[i];
                if (complete_s && (gnt_r == 1'(i))) begin
                    rdata_r[i] <= m_rdata;
                end
            end
        end
    end

    assign p0_ready = ready_r[0];
    assign p1_ready = ready_r[1];
    assign p0_rdata = rdata_r[0];
    assign p1_rdata = rdata_r[1];
    assign p0_busy  = pend_r[0];
    assign p1_busy  = pend_r[1];
    assign p0_err   = err_r[0];
    assign p1_err   = err_r[1];

endmodule

// File: tb/tb_apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_req_arbiter
// Drives a round-robin instance (index 0) and a fixed-priority instance
// (index 1) with identical stimulus. A transaction-level reference model
// tracks, per instance, the buffered requests, the request in service and
// how long it has been in service, and predicts every output each cycle.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_apb_req_arbiter;

    logic        PCLK;
    logic        PRESET;
    logic [1:0]  xfer;
    logic [31:0] in_addr  [2];
    logic [31:0] in_wdata [2];
    logic [1:0]  in_write;
    logic        m_ready;
    logic [31:0] m_rdata;

    logic        d_mt  [2];
    logic [31:0] d_ma  [2];
    logic [31:0] d_mwd [2];
    logic        d_mw  [2];
    logic        d_rdy  [2][2];
    logic [31:0] d_rd   [2][2];
    logic        d_busy [2][2];
    logic        d_err  [2][2];

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    apb_req_arbiter #(.RR_EN(1'b1)) u_rr (
        .PCLK(PCLK), .PRESET(PRESET),
        .p0_transfer(xfer[0]), .p0_addr(in_addr[0]), .p0_wdata(in_wdata[0]), .p0_write(in_write[0]),
        .p0_ready(d_rdy[0][0]), .p0_rdata(d_rd[0][0]), .p0_busy(d_busy[0][0]), .p0_err(d_err[0][0]),
        .p1_transfer(xfer[1]), .p1_addr(in_addr[1]), .p1_wdata(in_wdata[1]), .p1_write(in_write[1]),
        .p1_ready(d_rdy[0][1]), .p1_rdata(d_rd[0][1]), .p1_busy(d_busy[0][1]), .p1_err(d_err[0][1]),
        .m_transfer(d_mt[0]), .m_addr(d_ma[0]), .m_wdata(d_mwd[0]), .m_write(d_mw[0]),
        .m_ready(m_ready), .m_rdata(m_rdata)
    );

    apb_req_arbiter #(.RR_EN(1'b0)) u_fx (
        .PCLK(PCLK), .PRESET(PRESET),
        .p0_transfer(xfer[0]), .p0_addr(in_addr[0]), .p0_wdata(in_wdata[0]), .p0_write(in_write[0]),
        .p0_ready(d_rdy[1][0]), .p0_rdata(d_rd[1][0]), .p0_busy(d_busy[1][0]), .p0_err(d_err[1][0]),
        .p1_transfer(xfer[1]), .p1_addr(in_addr[1]), .p1_wdata(in_wdata[1]), .p1_write(in_write[1]),
        .p1_ready(d_rdy[1][1]), .p1_rdata(d_rd[1][1]), .p1_busy(d_busy[1][1]), .p1_err(d_err[1][1]),
        .m_transfer(d_mt[1]), .m_addr(d_ma[1]), .m_wdata(d_mwd[1]), .m_write(d_mw[1]),
        .m_ready(m_ready), .m_rdata(m_rdata)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // ---------------- reference model ----------------
    int          md_cur  [2];      // port in service, -1 when none
    int          md_age  [2];      // cycles since issue (1 = setup cycle)
    int          md_last [2];      // port granted most recently
    bit          md_pend [2][2];
    logic [31:0] md_addr [2][2];
    logic [31:0] md_wdat [2][2];
    bit          md_wr   [2][2];
    bit          md_rdy  [2][2];
    bit          md_err  [2][2];
    logic [31:0] md_rd   [2][2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            md_cur[k] = -1; md_age[k] = 0; md_last[k] = 1;
            for (int i = 0; i < 2; i++) begin
                md_pend[k][i] = 1'b0; md_addr[k][i] = 32'd0; md_wdat[k][i] = 32'd0;
                md_wr[k][i] = 1'b0; md_rdy[k][i] = 1'b0; md_err[k][i] = 1'b0;
                md_rd[k][i] = 32'd0;
            end
        end
    endtask

    // Who would be issued now if the master were free (-1 if nobody waits)
    function automatic int winner(input int k);
        if (md_pend[k][0] && md_pend[k][1]) begin
            if (k == 0) return (md_last[k] == 0) ? 1 : 0;
            return 0;
        end
        if (md_pend[k][0]) return 0;
        if (md_pend[k][1]) return 1;
        return -1;
    endfunction

    task automatic model_edge();
        if (PRESET) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            int  w;
            bit  comp;
            w    = (md_cur[k] < 0) ? winner(k) : -1;
            comp = (md_cur[k] >= 0) && (md_age[k] >= 2) && m_ready;
            for (int i = 0; i < 2; i++) begin
                md_rdy[k][i] = comp && (md_cur[k] == i);
                if (md_rdy[k][i]) md_rd[k][i] = m_rdata;
                md_err[k][i] = xfer[i] && md_pend[k][i];
                if (xfer[i] && !md_pend[k][i]) begin
                    md_pend[k][i] = 1'b1;
                    md_addr[k][i] = in_addr[i];
                    md_wdat[k][i] = in_wdata[i];
                    md_wr[k][i]   = in_write[i];
                end
            end
            if (comp) begin
                md_pend[k][md_cur[k]] = 1'b0;
                md_cur[k] = -1;
            end else if (md_cur[k] >= 0) begin
                md_age[k]++;
            end else if (w >= 0) begin
                md_cur[k] = w; md_age[k] = 1; md_last[k] = w;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            int          w;
            int          s;
            logic [31:0] ea;
            logic [31:0] ed;
            logic        ew;
            w  = (md_cur[k] < 0) ? winner(k) : -1;
            s  = (md_cur[k] >= 0) ? md_cur[k] : w;
            ea = 32'd0; ed = 32'd0; ew = 1'b0;
            if (s >= 0) begin
                ea = md_addr[k][s]; ed = md_wdat[k][s]; ew = md_wr[k][s];
            end
            chk($sformatf("i%0d m_transfer", k), 32'(d_mt[k]), 32'(w >= 0));
            chk($sformatf("i%0d m_addr", k), d_ma[k], ea);
            chk($sformatf("i%0d m_wdata", k), d_mwd[k], ed);
            chk($sformatf("i%0d m_write", k), 32'(d_mw[k]), 32'(ew));
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("i%0d p%0d_ready", k, i), 32'(d_rdy[k][i]), 32'(md_rdy[k][i]));
                chk($sformatf("i%0d p%0d_rdata", k, i), d_rd[k][i], md_rd[k][i]);
                chk($sformatf("i%0d p%0d_busy", k, i), 32'(d_busy[k][i]), 32'(md_pend[k][i]));
                chk($sformatf("i%0d p%0d_err", k, i), 32'(d_err[k][i]), 32'(md_err[k][i]));
            end
        end
    endtask

    task automatic sample();
        @(negedge PCLK);
    endtask

    task automatic advance();
        check_model();
        model_edge();
        @(posedge PCLK);
        #1;
        cyc++;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic set_reset(input logic v);
        PRESET = v;
        if (v) model_reset();
    endtask

    task automatic idle_inputs();
        xfer = 2'b00; in_write = 2'b00; m_ready = 1'b0; m_rdata = 32'd0;
        for (int i = 0; i < 2; i++) begin
            in_addr[i] = 32'd0; in_wdata[i] = 32'd0;
        end
    endtask

    task automatic reset_dut();
        set_reset(1'b1);
        step();
        step();
        set_reset(1'b0);
    endtask

    // ---------------- directed table (round-robin instance, port 0) ----------------
    typedef struct {
        logic        t0;
        logic [31:0] a0;
        logic        mr;
        logic [31:0] md;
        logic        e_mt;
        logic [31:0] e_ma;
        logic        e_rdy;
        logic [31:0] e_rd;
        logic        e_busy;
        logic        e_err;
    } vec_t;

    vec_t tbl [11];

    // Contention rounds: record issued addresses and cycles per instance
    int          iss_t [2][$];
    logic [31:0] iss_a [2][$];

    task automatic contention_round(input logic [31:0] e_rr0, input logic [31:0] e_rr1);
        for (int k = 0; k < 2; k++) begin
            iss_t[k].delete();
            iss_a[k].delete();
        end
        xfer = 2'b11; in_write = 2'b00;
        in_addr[0] = 32'hA000_0000; in_addr[1] = 32'hB000_0000;
        m_ready = 1'b1; m_rdata = $urandom;
        for (int c = 0; c < 10; c++) begin
            sample();
            for (int k = 0; k < 2; k++) begin
                if (d_mt[k]) begin
                    iss_t[k].push_back(cyc);
                    iss_a[k].push_back(d_ma[k]);
                end
            end
            advance();
            xfer = 2'b00;
        end
        chk("rr issue count", 32'(iss_a[0].size()), 32'd2);
        chk("fx issue count", 32'(iss_a[1].size()), 32'd2);
        if (iss_a[0].size() >= 2) begin
            chk("rr first winner", iss_a[0][0], e_rr0);
            chk("rr second winner", iss_a[0][1], e_rr1);
            chk("rr issue spacing", 32'(iss_t[0][1] - iss_t[0][0]), 32'd3);
        end
        if (iss_a[1].size() >= 2) begin
            chk("fx first winner", iss_a[1][0], 32'hA000_0000);
            chk("fx second winner", iss_a[1][1], 32'hB000_0000);
        end
        m_ready = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'h1000_0004, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0};
        tbl[1]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h1000_0004, 1'b0, 32'h0,         1'b1, 1'b0};
        tbl[2]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h1000_0004, 1'b0, 32'h0,         1'b1, 1'b0};
        tbl[3]  = '{1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 32'h1000_0004, 1'b0, 32'h0,         1'b1, 1'b0};
        tbl[4]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 32'h1000_0010, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 32'h2000_0020, 1'b0, 32'h0,         1'b1, 32'h1000_0010, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 32'h0,         1'b1, 32'h0000_0BAD, 1'b0, 32'h1000_0010, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 32'h3000_0030, 1'b1, 32'h0000_0055, 1'b0, 32'h1000_0010, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0055, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0055, 1'b0, 1'b0};

        idle_inputs();
        set_reset(1'b1);
        // Inputs active during reset must have no effect
        xfer = 2'b11; m_ready = 1'b1;
        sample();
        chk("reset m_transfer", 32'(d_mt[0]), 32'd0);
        chk("reset p0_busy", 32'(d_busy[0][0]), 32'd0);
        chk("reset p1_ready", 32'(d_rdy[0][1]), 32'd0);
        advance();
        step();
        idle_inputs();
        set_reset(1'b0);
        step();

        // Single read and overrun, with constant expectations
        for (int r = 0; r < 11; r++) begin
            xfer[0] = tbl[r].t0; in_addr[0] = tbl[r].a0;
            m_ready = tbl[r].mr; m_rdata = tbl[r].md;
            sample();
            chk($sformatf("tbl%0d m_transfer", r), 32'(d_mt[0]), 32'(tbl[r].e_mt));
            chk($sformatf("tbl%0d m_addr", r), d_ma[0], tbl[r].e_ma);
            chk($sformatf("tbl%0d p0_ready", r), 32'(d_rdy[0][0]), 32'(tbl[r].e_rdy));
            chk($sformatf("tbl%0d p0_rdata", r), d_rd[0][0], tbl[r].e_rd);
            chk($sformatf("tbl%0d p0_busy", r), 32'(d_busy[0][0]), 32'(tbl[r].e_busy));
            chk($sformatf("tbl%0d p0_err", r), 32'(d_err[0][0]), 32'(tbl[r].e_err));
            advance();
        end
        idle_inputs();

        // Contention: after reset port 0 wins; a lone port-0 request then
        // makes port 1 the round-robin favourite for the next contest.
        reset_dut();
        contention_round(32'hA000_0000, 32'hB000_0000);
        xfer = 2'b01; in_addr[0] = 32'hC000_0000; m_ready = 1'b1;
        step();
        xfer = 2'b00;
        for (int c = 0; c < 5; c++) step();
        contention_round(32'hB000_0000, 32'hA000_0000);
        idle_inputs();
        step();

        // Wait states on a port-1 write, ready high during setup
        xfer = 2'b10; in_addr[1] = 32'h1000_3000; in_wdata[1] = 32'h1234_5678; in_write = 2'b10;
        step();
        xfer = 2'b00;
        for (int c = 1; c <= 9; c++) begin
            m_ready = (c == 2 || c == 8);
            sample();
            if (c <= 8) begin
                chk($sformatf("ws%0d m_addr", c), d_ma[0], 32'h1000_3000);
                chk($sformatf("ws%0d m_wdata", c), d_mwd[0], 32'h1234_5678);
                chk($sformatf("ws%0d p1_ready", c), 32'(d_rdy[0][1]), 32'd0);
            end else begin
                chk("ws p1_ready", 32'(d_rdy[0][1]), 32'd1);
                chk("ws p1_busy", 32'(d_busy[0][1]), 32'd0);
            end
            advance();
        end
        idle_inputs();

        // Reset during ACCESS abandons the transfer without retry
        xfer = 2'b01; in_addr[0] = 32'h4000_0000;
        step();
        xfer = 2'b00;
        step(); step(); step();
        set_reset(1'b1);
        m_ready = 1'b1;
        sample();
        chk("rst busy", 32'(d_busy[0][0]), 32'd0);
        chk("rst ready", 32'(d_rdy[0][0]), 32'd0);
        advance();
        step();
        set_reset(1'b0);
        m_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sample();
            chk("post-rst p0_ready", 32'(d_rdy[0][0]), 32'd0);
            chk("post-rst m_transfer", 32'(d_mt[0]), 32'd0);
            advance();
        end
        xfer = 2'b10; in_addr[1] = 32'h5000_0000;
        step();
        xfer = 2'b00; m_ready = 1'b1; m_rdata = 32'hCAFE_F00D;
        step(); step(); step();
        m_ready = 1'b0;
        sample();
        chk("post-rst p1_ready", 32'(d_rdy[0][1]), 32'd1);
        chk("post-rst p1_rdata", d_rd[0][1], 32'hCAFE_F00D);
        advance();

        // Randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            set_reset(1'($urandom_range(0, 149) == 0));
            xfer[0] = ($urandom_range(0, 3) == 0);
            xfer[1] = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 2; i++) begin
                in_addr[i]  = $urandom;
                in_wdata[i] = $urandom;
            end
            in_write = 2'($urandom_range(0, 3));
            m_ready  = 1'($urandom_range(0, 1));
            m_rdata  = $urandom;
            step();
        end
        set_reset(1'b0);
        idle_inputs();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
